// File: rtl/cache_pkg.sv
// Shared types for the cache-core request port and its arbiter.
package cache_pkg;

    localparam int unsigned CORE_ADDR_W = 32;
    localparam int unsigned CORE_DATA_W = 32;
    localparam int unsigned CORE_STRB_W = CORE_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        A_IDLE  = 2'b00,
        A_ISSUE = 2'b01,
        A_WAIT  = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic                   we;
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wdata;
        logic [CORE_STRB_W-1:0] wstrb;
    } core_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester other than `last` wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    // Single requester wins outright; a tie goes away from the last winner.
    always_comb begin
        any    = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/core_port_arbiter.sv
// Shares the single cache-core request port between two requesters,
// one transaction in flight, round-robin grant.
module core_port_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic                    m0_req_we,
    input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
    input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
    output logic                    m0_resp_valid,
    output logic                    m0_resp_is_write,
    output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
    output logic [1:0]              m0_resp_resp,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic                    m1_req_we,
    input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
    input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
    output logic                    m1_resp_valid,
    output logic                    m1_resp_is_write,
    output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
    output logic [1:0]              m1_resp_resp,

    output logic                    core_req_valid,
    input  logic                    core_req_ready,
    output logic                    core_req_we,
    output logic [ADDR_WIDTH-1:0]   core_req_addr,
    output logic [DATA_WIDTH-1:0]   core_req_wdata,
    output logic [DATA_WIDTH/8-1:0] core_req_wstrb,
    input  logic                    core_resp_valid,
    input  logic                    core_resp_is_write,
    input  logic [DATA_WIDTH-1:0]   core_resp_rdata,
    input  logic [1:0]              core_resp_resp,

    output logic [1:0]              dbg_state,
    output logic                    dbg_grant,
    output logic                    dbg_stray
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_t              state;
    logic                    grant;
    logic                    rr_last;
    logic                    stray;
    logic                    hold_we;
    logic [ADDR_WIDTH-1:0]   hold_addr;
    logic [DATA_WIDTH-1:0]   hold_wdata;
    logic [STRB_WIDTH-1:0]   hold_wstrb;

    logic                    winner;
    logic                    any;
    logic                    in_idle;
    logic                    in_issue;
    logic                    in_wait;
    logic                    complete;
    logic                    stray_hit;

    rr_pick2 u_pick (
        .req    ({m1_req_valid, m0_req_valid}),
        .last   (rr_last),
        .winner (winner),
        .any    (any)
    );

    // Decode state and classify the core response for this cycle.
    always_comb begin
        in_idle   = (state == A_IDLE);
        in_issue  = (state == A_ISSUE);
        in_wait   = (state == A_WAIT);
        complete  = core_resp_valid && (in_wait || (in_issue && core_req_ready));
        stray_hit = core_resp_valid && !complete;
    end

    // Arbiter FSM with holding registers, grant and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= A_IDLE;
            grant      <= 1'b0;
            rr_last    <= 1'b1;
            stray      <= 1'b0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_wstrb <= '0;
        end else begin
            if (stray_hit) begin
                stray <= 1'b1;
            end
            case (state)
                A_IDLE: begin
                    if (any) begin
                        state      <= A_ISSUE;
                        grant      <= winner;
                        hold_we    <= winner ? m1_req_we    : m0_req_we;
                        hold_addr  <= winner ? m1_req_addr  : m0_req_addr;
                        hold_wdata <= winner ? m1_req_wdata : m0_req_wdata;
                        hold_wstrb <= winner ? m1_req_wstrb : m0_req_wstrb;
                    end
                end
                A_ISSUE: begin
                    if (core_req_ready) begin
                        if (core_resp_valid) begin
                            state   <= A_IDLE;
                            rr_last <= grant;
                        end else begin
                            state <= A_WAIT;
                        end
                    end
                end
                A_WAIT: begin
                    if (core_resp_valid) begin
                        state   <= A_IDLE;
                        rr_last <= grant;
                    end
                end
                default: state <= A_IDLE;
            endcase
        end
    end

    // Requester handshake and response routing to the granted side only.
    always_comb begin
        m0_req_ready     = in_idle && any && (winner == 1'b0);
        m1_req_ready     = in_idle && any && (winner == 1'b1);
        m0_resp_valid    = complete && (grant == 1'b0);
        m1_resp_valid    = complete && (grant == 1'b1);
        m0_resp_is_write = 1'b0;
        m0_resp_rdata    = '0;
        m0_resp_resp     = 2'b00;
        m1_resp_is_write = 1'b0;
        m1_resp_rdata    = '0;
        m1_resp_resp     = 2'b00;
        if (grant == 1'b0) begin
            m0_resp_is_write = core_resp_is_write;
            m0_resp_rdata    = core_resp_rdata;
            m0_resp_resp     = core_resp_resp;
        end else begin
            m1_resp_is_write = core_resp_is_write;
            m1_resp_rdata    = core_resp_rdata;
            m1_resp_resp     = core_resp_resp;
        end
    end

    // Core request side is driven purely from registered state.
    always_comb begin
        core_req_valid = in_issue;
        core_req_we    = hold_we;
        core_req_addr  = hold_addr;
        core_req_wdata = hold_wdata;
        core_req_wstrb = hold_wstrb;
        dbg_state      = 2'(state);
        dbg_grant      = grant;
        dbg_stray      = stray;
    end

endmodule

// File: tb/tb_core_port_arbiter.sv
// Directed and randomized checks of core_port_arbiter against a
// transaction-level reference model.
module tb_core_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic [3:0]  m0_req_wstrb;
    logic        m0_resp_valid, m0_resp_is_write;
    logic [31:0] m0_resp_rdata;
    logic [1:0]  m0_resp_resp;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic [3:0]  m1_req_wstrb;
    logic        m1_resp_valid, m1_resp_is_write;
    logic [31:0] m1_resp_rdata;
    logic [1:0]  m1_resp_resp;
    logic        core_req_valid, core_req_ready, core_req_we;
    logic [31:0] core_req_addr, core_req_wdata;
    logic [3:0]  core_req_wstrb;
    logic        core_resp_valid, core_resp_is_write;
    logic [31:0] core_resp_rdata;
    logic [1:0]  core_resp_resp;
    logic [1:0]  dbg_state;
    logic        dbg_grant, dbg_stray;

    core_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
        .m0_resp_valid(m0_resp_valid), .m0_resp_is_write(m0_resp_is_write),
        .m0_resp_rdata(m0_resp_rdata), .m0_resp_resp(m0_resp_resp),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
        .m1_resp_valid(m1_resp_valid), .m1_resp_is_write(m1_resp_is_write),
        .m1_resp_rdata(m1_resp_rdata), .m1_resp_resp(m1_resp_resp),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_we(core_req_we),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata), .core_req_wstrb(core_req_wstrb),
        .core_resp_valid(core_resp_valid), .core_resp_is_write(core_resp_is_write),
        .core_resp_rdata(core_resp_rdata), .core_resp_resp(core_resp_resp),
        .dbg_state(dbg_state), .dbg_grant(dbg_grant), .dbg_stray(dbg_stray)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: one outstanding transaction, described by whether it
    // exists, whether the core has taken it, who owns it and what it carries.
    bit          mdl_pend  = 1'b0;
    bit          mdl_taken = 1'b0;
    bit          mdl_owner = 1'b0;
    bit          mdl_prev  = 1'b1;
    bit          mdl_stray = 1'b0;
    logic        mdl_we    = 1'b0;
    logic [31:0] mdl_addr  = '0;
    logic [31:0] mdl_wdata = '0;
    logic [3:0]  mdl_wstrb = '0;

    int          dut_resp_log[$];
    logic [31:0] dut_issue_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Who would the model hand the port to right now, if it were free.
    function automatic void mdl_choose(output bit w, output bit a);
        a = m0_req_valid || m1_req_valid;
        if (m0_req_valid && m1_req_valid) w = (mdl_prev == 1'b0) ? 1'b1 : 1'b0;
        else                              w = m1_req_valid;
    endfunction

    function automatic bit mdl_finishing();
        return mdl_pend && core_resp_valid && (mdl_taken || core_req_ready);
    endfunction

    task automatic sample();
        bit w, a, done;
        logic [1:0] st;
        @(negedge clk);
        if (m0_resp_valid === 1'b1) dut_resp_log.push_back(0);
        if (m1_resp_valid === 1'b1) dut_resp_log.push_back(1);
        if (core_req_valid === 1'b1 && core_req_ready) dut_issue_log.push_back(core_req_addr);
        if (!chk_en) return;
        mdl_choose(w, a);
        done = mdl_finishing();
        st = !mdl_pend ? 2'd0 : (mdl_taken ? 2'd2 : 2'd1);
        chk("m0_req_ready", 64'(m0_req_ready), 64'(!mdl_pend && a && !w));
        chk("m1_req_ready", 64'(m1_req_ready), 64'(!mdl_pend && a && w));
        chk("core_req_valid", 64'(core_req_valid), 64'(mdl_pend && !mdl_taken));
        if (mdl_pend && !mdl_taken)
            chk("core_req_fields", 64'({core_req_we, core_req_addr, core_req_wstrb}),
                64'({mdl_we, mdl_addr, mdl_wstrb}));
        if (mdl_pend && !mdl_taken) chk("core_req_wdata", 64'(core_req_wdata), 64'(mdl_wdata));
        chk("m0_resp_valid", 64'(m0_resp_valid), 64'(done && !mdl_owner));
        chk("m1_resp_valid", 64'(m1_resp_valid), 64'(done && mdl_owner));
        if (!mdl_owner) begin
            chk("m0_resp_fields", 64'({m0_resp_is_write, m0_resp_rdata, m0_resp_resp}),
                64'({core_resp_is_write, core_resp_rdata, core_resp_resp}));
            chk("m1_resp_zero", 64'({m1_resp_is_write, m1_resp_rdata, m1_resp_resp}), 64'(0));
        end else begin
            chk("m1_resp_fields", 64'({m1_resp_is_write, m1_resp_rdata, m1_resp_resp}),
                64'({core_resp_is_write, core_resp_rdata, core_resp_resp}));
            chk("m0_resp_zero", 64'({m0_resp_is_write, m0_resp_rdata, m0_resp_resp}), 64'(0));
        end
        chk("dbg_stray", 64'(dbg_stray), 64'(mdl_stray));
        chk("dbg_grant", 64'(dbg_grant), 64'(mdl_owner));
        chk("dbg_state", 64'(dbg_state), 64'(st));
    endtask

    task automatic model_step();
        bit w, a, done, odd;
        if (rst) begin
            mdl_pend = 0; mdl_taken = 0; mdl_owner = 0; mdl_prev = 1; mdl_stray = 0;
            mdl_we = 0; mdl_addr = '0; mdl_wdata = '0; mdl_wstrb = '0;
            return;
        end
        done = mdl_finishing();
        odd  = core_resp_valid && !done;
        if (!mdl_pend) begin
            mdl_choose(w, a);
            if (a) begin
                mdl_pend = 1; mdl_taken = 0; mdl_owner = w;
                mdl_we    = w ? m1_req_we    : m0_req_we;
                mdl_addr  = w ? m1_req_addr  : m0_req_addr;
                mdl_wdata = w ? m1_req_wdata : m0_req_wdata;
                mdl_wstrb = w ? m1_req_wstrb : m0_req_wstrb;
            end
        end else if (done) begin
            mdl_pend = 0; mdl_prev = mdl_owner;
        end else if (core_req_ready) begin
            mdl_taken = 1;
        end
        if (odd) mdl_stray = 1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic quiet();
        rst = 0;
        m0_req_valid = 0; m0_req_we = 0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_wstrb = '0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_wstrb = '0;
        core_req_ready = 0; core_resp_valid = 0; core_resp_is_write = 0;
        core_resp_rdata = '0; core_resp_resp = 2'b00;
    endtask

    task automatic do_reset_and_check(input string tag);
        quiet();
        rst = 1;
        tick();
        rst = 0;
        sample();
        chk({tag, "_outs_zero"}, 64'({m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
            core_req_valid, core_req_we, core_req_wstrb, dbg_state, dbg_grant, dbg_stray}), 64'(0));
        chk({tag, "_addr_zero"}, 64'({core_req_addr, core_req_wdata}), 64'(0));
        chk({tag, "_resp_zero"}, 64'({m0_resp_rdata, m1_resp_rdata, m0_resp_resp, m1_resp_resp,
            m0_resp_is_write, m1_resp_is_write}), 64'(0));
        advance();
    endtask

    initial begin
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wstrb;
        int          exp_seq[6];

        quiet();
        rst = 1;
        tick(); tick();
        chk_en = 1'b1;
        do_reset_and_check("reset");

        // Single read from m0.
        m0_req_valid = 1; m0_req_addr = 32'h0000_0010;
        sample(); chk("rd_ready_T", 64'(m0_req_ready), 64'(1)); advance();
        m0_req_valid = 0;
        sample(); chk("rd_issue_T1", 64'({core_req_valid, core_req_addr}), 64'({1'b1, 32'h10})); advance();
        tick();
        core_req_ready = 1;
        tick();
        core_req_ready = 0;
        tick();
        core_resp_valid = 1; core_resp_rdata = 32'hDEAD_BEEF;
        sample();
        chk("rd_resp_T5", 64'({m0_resp_valid, m0_resp_rdata}), 64'({1'b1, 32'hDEAD_BEEF}));
        chk("rd_m1_quiet", 64'(m1_resp_valid), 64'(0));
        advance();
        quiet();
        tick();

        // Simultaneous writes after reset: m0 first, then m1.
        do_reset_and_check("reset2");
        m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 32'h20;
        m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 32'h30;
        sample(); chk("sim_m0_first", 64'({m0_req_ready, m1_req_ready}), 64'(2'b10)); advance();
        m0_req_valid = 0; core_req_ready = 1;
        sample(); chk("sim_m1_wait_a", 64'(m1_req_ready), 64'(0)); advance();
        core_req_ready = 0; core_resp_valid = 1;
        sample(); chk("sim_m1_wait_b", 64'({m1_req_ready, m0_resp_valid}), 64'(2'b01)); advance();
        core_resp_valid = 0;
        sample(); chk("sim_m1_ready", 64'({m1_req_ready, dbg_grant}), 64'(2'b10)); advance();
        m1_req_valid = 0;
        sample(); chk("sim_m1_issue", 64'({core_req_valid, core_req_addr, dbg_grant}),
                      64'({1'b1, 32'h30, 1'b1})); advance();
        core_req_ready = 1; core_resp_valid = 1;
        tick();
        quiet();
        tick();

        // Fairness under continuous contention with a zero-wait core.
        do_reset_and_check("reset3");
        dut_resp_log.delete();
        dut_issue_log.delete();
        m0_req_valid = 1; m0_req_addr = 32'h100;
        m1_req_valid = 1; m1_req_addr = 32'h200;
        core_req_ready = 1; core_resp_valid = 1;
        repeat (12) tick();
        quiet();
        tick();
        exp_seq = '{0, 1, 0, 1, 0, 1};
        chk("fair_count", 64'(dut_resp_log.size()), 64'(6));
        chk("fair_issues", 64'(dut_issue_log.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < dut_resp_log.size()) chk($sformatf("fair_grant_%0d", i), 64'(dut_resp_log[i]), 64'(exp_seq[i]));
            if (i < dut_issue_log.size())
                chk($sformatf("fair_addr_%0d", i), 64'(dut_issue_log[i]), 64'(exp_seq[i] == 0 ? 32'h100 : 32'h200));
        end

        // Stall hold, combined handshake, then a stray response in idle.
        do_reset_and_check("reset4");
        m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 32'h44; m1_req_wdata = 32'h1234_5678; m1_req_wstrb = 4'h5;
        tick();
        m1_req_valid = 0; m1_req_addr = 32'hFFFF_FFFF; m1_req_wdata = '0; m1_req_wstrb = 4'hF;
        s_addr = 32'h44; s_wdata = 32'h1234_5678; s_wstrb = 4'h5;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk($sformatf("stall_hold_%0d", i), 64'({core_req_valid, core_req_addr, core_req_wstrb}),
                64'({1'b1, s_addr, s_wstrb}));
            chk($sformatf("stall_wdata_%0d", i), 64'(core_req_wdata), 64'(s_wdata));
            advance();
        end
        core_req_ready = 1; core_resp_valid = 1; core_resp_resp = 2'b10;
        sample(); chk("comb_resp", 64'({m1_resp_valid, m1_resp_resp}), 64'({1'b1, 2'b10})); advance();
        quiet();
        sample(); chk("comb_idle_next", 64'(dbg_state), 64'(0)); advance();
        core_resp_valid = 1; core_resp_rdata = 32'h5555;
        sample(); chk("stray_no_fwd", 64'({m0_resp_valid, m1_resp_valid}), 64'(0)); advance();
        core_resp_valid = 0;
        sample(); chk("stray_set", 64'({dbg_stray, dbg_state}), 64'({1'b1, 2'b00})); advance();

        // Reset while waiting for the core, then recovery.
        do_reset_and_check("reset5");
        m0_req_valid = 1; m0_req_addr = 32'h60;
        tick();
        m0_req_valid = 0; core_req_ready = 1;
        tick();
        core_req_ready = 0;
        sample(); chk("rw_in_wait", 64'(dbg_state), 64'(2)); advance();
        do_reset_and_check("reset_wait");
        core_resp_valid = 1; core_resp_rdata = 32'h7777;
        sample(); chk("rw_late_no_fwd", 64'({m0_resp_valid, m1_resp_valid}), 64'(0)); advance();
        core_resp_valid = 0;
        sample(); chk("rw_late_stray", 64'(dbg_stray), 64'(1)); advance();
        m1_req_valid = 1; m1_req_addr = 32'h80;
        sample(); chk("rw_m1_ready", 64'(m1_req_ready), 64'(1)); advance();
        m1_req_valid = 0; core_req_ready = 1;
        sample(); chk("rw_m1_issue", 64'({core_req_valid, core_req_addr}), 64'({1'b1, 32'h80})); advance();
        core_req_ready = 0; core_resp_valid = 1; core_resp_rdata = 32'hCAFE_F00D;
        sample(); chk("rw_m1_resp", 64'({m1_resp_valid, m1_resp_rdata, m0_resp_valid}),
                      64'({1'b1, 32'hCAFE_F00D, 1'b0})); advance();
        quiet();
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 99) == 0);
            m0_req_valid    = ($urandom_range(0, 2) != 0);
            m0_req_we       = 1'($urandom);
            m0_req_addr     = $urandom;
            m0_req_wdata    = $urandom;
            m0_req_wstrb    = 4'($urandom);
            m1_req_valid    = ($urandom_range(0, 2) != 0);
            m1_req_we       = 1'($urandom);
            m1_req_addr     = $urandom;
            m1_req_wdata    = $urandom;
            m1_req_wstrb    = 4'($urandom);
            core_req_ready  = 1'($urandom);
            core_resp_valid = ($urandom_range(0, 3) == 0);
            core_resp_is_write = 1'($urandom);
            core_resp_rdata = $urandom;
            core_resp_resp  = 2'($urandom);
            tick();
        end
        quiet();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
